// File: rtl/image_sort_if.sv
// Pixel-in / sorted-record-out bundle for image_sort_engine.
// master = pixel source and result sink, slave = the engine.
interface image_sort_if #(
  parameter int N_IMG = 32,
  parameter int CW    = 8
);
  localparam int IDX_W = $clog2(N_IMG);

  logic             in_valid;
  logic [IDX_W-1:0] image_in_index;
  logic [3*CW-1:0]  pixel_in;
  logic             desc;
  logic             busy;
  logic             out_valid;
  logic [1:0]       color_index;
  logic [CW:0]      strength_out;
  logic [IDX_W-1:0] image_out_index;

  modport master (
    output in_valid, image_in_index, pixel_in, desc,
    input  busy, out_valid, color_index, strength_out, image_out_index
  );

  modport slave (
    input  in_valid, image_in_index, pixel_in, desc,
    output busy, out_valid, color_index, strength_out, image_out_index
  );
endinterface

// File: rtl/image_sort_engine.sv
// Classifies each image's dominant colour and strength, then sorts a full frame
// of records with odd-even transposition and streams them out in rank order.
module image_sort_engine #(
  parameter int N_IMG    = 32,
  parameter int PIX_LOG2 = 14,
  parameter int CW       = 8
) (
  input  logic        clk,
  input  logic        reset,
  image_sort_if.slave bus
);
  localparam int IDX_W  = $clog2(N_IMG);
  localparam int CNT_W  = PIX_LOG2 + 1;
  localparam int SUM_W  = CW + PIX_LOG2;
  localparam int REM_W  = SUM_W + 1;
  localparam int DCNT_W = $clog2(CW + 1);
  localparam int SLOT_W = IDX_W + 1;

  typedef enum logic [2:0] {S_ACCUM, S_DIV, S_STORE, S_SORT, S_OUT} state_e;

  typedef struct packed {
    logic [1:0]       color;
    logic [CW:0]      strength;
    logic [IDX_W-1:0] idx;
  } rec_t;

  state_e              state_q, state_d;
  logic                busy_q;
  logic [PIX_LOG2-1:0] pix_cnt_q, pix_cnt_d;
  logic [CNT_W-1:0]    cnt_q [3];
  logic [CNT_W-1:0]    cnt_d [3];
  logic [SUM_W-1:0]    sum_q [3];
  logic [SUM_W-1:0]    sum_d [3];
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DCNT_W-1:0]   div_cnt_q, div_cnt_d;
  logic [REM_W-1:0]    rem_q, rem_d;
  logic [CW:0]         quo_q, quo_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [IDX_W-1:0]    sort_cnt_q, sort_cnt_d;
  logic [IDX_W-1:0]    out_cnt_q, out_cnt_d;
  logic                desc_q, desc_d;
  rec_t                rec_q [N_IMG];
  rec_t                rec_d [N_IMG];
  logic                out_valid_q, out_valid_d;
  logic [1:0]          color_q, color_d;
  logic [CW:0]         strength_q, strength_d;
  logic [IDX_W-1:0]    oidx_q, oidx_d;

  // Pixel classification: ties resolve R > G > B.
  logic [CW-1:0] pr, pg, pb, pix_val;
  logic [1:0]    pix_cls;
  assign pr = bus.pixel_in[3*CW-1:2*CW];
  assign pg = bus.pixel_in[2*CW-1:CW];
  assign pb = bus.pixel_in[CW-1:0];

  always_comb begin
    pix_cls = 2'd2;
    pix_val = pb;
    if (pr >= pg && pr >= pb) begin
      pix_cls = 2'd0;
      pix_val = pr;
    end else if (pg >= pb) begin
      pix_cls = 2'd1;
      pix_val = pg;
    end
  end

  logic [1:0]       win_cls;
  logic [CNT_W-1:0] win_cnt;
  logic [SUM_W-1:0] win_sum;

  always_comb begin
    win_cls = 2'd2;
    win_cnt = cnt_q[2];
    win_sum = sum_q[2];
    if (cnt_q[0] >= cnt_q[1] && cnt_q[0] >= cnt_q[2]) begin
      win_cls = 2'd0;
      win_cnt = cnt_q[0];
      win_sum = sum_q[0];
    end else if (cnt_q[1] >= cnt_q[2]) begin
      win_cls = 2'd1;
      win_cnt = cnt_q[1];
      win_sum = sum_q[1];
    end
  end

  // Quotient is known to fit CW+1 bits, so only those bit positions are tried.
  logic [REM_W-1:0] rem_cur, div_shift;
  logic             div_fit;

  always_comb begin
    rem_cur   = (div_cnt_q == '0) ? {win_sum, 1'b0} : rem_q;
    div_shift = REM_W'(win_cnt) << (DCNT_W'(CW) - div_cnt_q);
    div_fit   = (rem_cur >= div_shift);
  end

  function automatic logic ranks_after(input rec_t l, input rec_t r, input logic d);
    if (l.color != r.color)
      return l.color > r.color;
    if (l.strength != r.strength)
      return d ? (l.strength < r.strength) : (l.strength > r.strength);
    return l.idx > r.idx;
  endfunction

  logic [N_IMG-2:0] swap_w;
  generate
    for (genvar gi = 0; gi < N_IMG - 1; gi++) begin : g_cmp
      assign swap_w[gi] = ranks_after(rec_q[gi], rec_q[gi+1], desc_q);
    end
  endgenerate

  always_comb begin
    state_d    = state_q;
    pix_cnt_d  = pix_cnt_q;
    idx_d      = idx_q;
    div_cnt_d  = div_cnt_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    slot_d     = slot_q;
    sort_cnt_d = sort_cnt_q;
    out_cnt_d  = out_cnt_q;
    desc_d     = desc_q;
    rec_d      = rec_q;
    for (int c = 0; c < 3; c++) begin
      cnt_d[c] = cnt_q[c];
      sum_d[c] = sum_q[c];
    end

    unique case (state_q)
      S_ACCUM: begin
        if (bus.in_valid && !busy_q) begin
          pix_cnt_d = pix_cnt_q + 1'b1;
          if (pix_cnt_q == '0)
            idx_d = bus.image_in_index;
          for (int c = 0; c < 3; c++) begin
            if (pix_cls == 2'(c)) begin
              cnt_d[c] = cnt_q[c] + 1'b1;
              sum_d[c] = sum_q[c] + SUM_W'(pix_val);
            end
          end
          if (pix_cnt_q == '1) begin
            state_d   = S_DIV;
            div_cnt_d = '0;
          end
        end
      end
      S_DIV: begin
        rem_d     = div_fit ? (rem_cur - div_shift) : rem_cur;
        quo_d     = {quo_q[CW-1:0], div_fit};
        div_cnt_d = div_cnt_q + 1'b1;
        if (div_cnt_q == DCNT_W'(CW)) begin
          state_d   = S_STORE;
          div_cnt_d = '0;
        end
      end
      S_STORE: begin
        rec_d[slot_q[IDX_W-1:0]] = '{color: win_cls, strength: quo_q, idx: idx_q};
        for (int c = 0; c < 3; c++) begin
          cnt_d[c] = '0;
          sum_d[c] = '0;
        end
        pix_cnt_d = '0;
        slot_d    = slot_q + 1'b1;
        if (slot_d == SLOT_W'(N_IMG)) begin
          state_d    = S_SORT;
          desc_d     = bus.desc;
          sort_cnt_d = '0;
        end else begin
          state_d = S_ACCUM;
        end
      end
      S_SORT: begin
        for (int i = 0; i < N_IMG - 1; i++) begin
          if ((i % 2) == int'(sort_cnt_q[0]) && swap_w[i]) begin
            rec_d[i]   = rec_q[i+1];
            rec_d[i+1] = rec_q[i];
          end
        end
        sort_cnt_d = sort_cnt_q + 1'b1;
        if (sort_cnt_q == IDX_W'(N_IMG - 1)) begin
          state_d   = S_OUT;
          out_cnt_d = '0;
        end
      end
      S_OUT: begin
        out_cnt_d = out_cnt_q + 1'b1;
        if (out_cnt_q == IDX_W'(N_IMG - 1)) begin
          state_d   = S_ACCUM;
          out_cnt_d = '0;
          slot_d    = '0;
        end
      end
      default: state_d = S_ACCUM;
    endcase
  end

  // Beat data is read from the post-sort-step array so slot 0 is final on OUT entry.
  logic [IDX_W-1:0] rd_ptr;

  always_comb begin
    rd_ptr      = (state_q == S_OUT) ? IDX_W'(out_cnt_q + 1'b1) : '0;
    out_valid_d = (state_d == S_OUT);
    color_d     = color_q;
    strength_d  = strength_q;
    oidx_d      = oidx_q;
    if (state_d == S_OUT) begin
      color_d    = rec_d[rd_ptr].color;
      strength_d = rec_d[rd_ptr].strength;
      oidx_d     = rec_d[rd_ptr].idx;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_ACCUM;
      busy_q      <= 1'b0;
      pix_cnt_q   <= '0;
      idx_q       <= '0;
      div_cnt_q   <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      slot_q      <= '0;
      sort_cnt_q  <= '0;
      out_cnt_q   <= '0;
      desc_q      <= 1'b0;
      out_valid_q <= 1'b0;
      color_q     <= '0;
      strength_q  <= '0;
      oidx_q      <= '0;
      for (int c = 0; c < 3; c++) begin
        cnt_q[c] <= '0;
        sum_q[c] <= '0;
      end
    end else begin
      state_q     <= state_d;
      busy_q      <= (state_d != S_ACCUM);
      pix_cnt_q   <= pix_cnt_d;
      idx_q       <= idx_d;
      div_cnt_q   <= div_cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      slot_q      <= slot_d;
      sort_cnt_q  <= sort_cnt_d;
      out_cnt_q   <= out_cnt_d;
      desc_q      <= desc_d;
      out_valid_q <= out_valid_d;
      color_q     <= color_d;
      strength_q  <= strength_d;
      oidx_q      <= oidx_d;
      for (int c = 0; c < 3; c++) begin
        cnt_q[c] <= cnt_d[c];
        sum_q[c] <= sum_d[c];
      end
    end
  end

  always_ff @(posedge clk) begin
    rec_q <= rec_d;
  end

  assign bus.busy            = busy_q;
  assign bus.out_valid       = out_valid_q;
  assign bus.color_index     = color_q;
  assign bus.strength_out    = strength_q;
  assign bus.image_out_index = oidx_q;
endmodule

// File: tb/tb_image_sort_engine.sv
// Directed bench for image_sort_engine at N_IMG=4, PIX=4, CW=8: sorting order,
// classification ties, strength flooring, handshake timing and mid-frame reset.
module tb_image_sort_engine;
  localparam int N_IMG    = 4;
  localparam int PIX_LOG2 = 2;
  localparam int CW       = 8;
  localparam logic [23:0] JUNK = 24'hFFFFFF;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  image_sort_if #(.N_IMG(N_IMG), .CW(CW)) bus ();

  image_sort_engine #(.N_IMG(N_IMG), .PIX_LOG2(PIX_LOG2), .CW(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [23:0] pix_tab [4][4];
  logic [1:0]  idx_tab [4];
  logic [1:0]  exp_col [4];
  logic [8:0]  exp_str [4];
  logic [1:0]  exp_idx [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_img(input int k, input logic [1:0] idx, input logic [23:0] p0,
                         input logic [23:0] p1, input logic [23:0] p2, input logic [23:0] p3);
    idx_tab[k]    = idx;
    pix_tab[k][0] = p0;
    pix_tab[k][1] = p1;
    pix_tab[k][2] = p2;
    pix_tab[k][3] = p3;
  endtask

  task automatic set_exp(input int b, input logic [1:0] col, input logic [8:0] str, input logic [1:0] idx);
    exp_col[b] = col;
    exp_str[b] = str;
    exp_idx[b] = idx;
  endtask

  task automatic send_pixel(input logic [23:0] pix, input logic [1:0] idx);
    int guard;
    if ($urandom_range(0, 2) == 0) begin
      bus.in_valid = 1'b0;
      bus.pixel_in = JUNK;
      step();
    end
    guard = 0;
    while (bus.busy !== 1'b0 && guard < 100) begin
      bus.in_valid = 1'b1;
      bus.pixel_in = JUNK;
      step();
      guard++;
    end
    if (guard >= 100) chk("accept_wait", guard, 0);
    bus.in_valid       = 1'b1;
    bus.pixel_in       = pix;
    bus.image_in_index = idx;
    step();
    bus.in_valid = 1'b0;
    bus.pixel_in = JUNK;
  endtask

  // Later pixels carry a wrong index: only the first accepted one may be sampled.
  task automatic send_image(input int k, input bit last, input bit flip, input string tag);
    int n;
    for (int p = 0; p < 4; p++)
      send_pixel(pix_tab[k][p], (p == 0) ? idx_tab[k] : ~idx_tab[k]);
    if (!last) begin
      n = 0;
      while (bus.busy === 1'b1 && n < 100) begin
        bus.in_valid = 1'b1;
        bus.pixel_in = JUNK;
        step();
        n++;
      end
      bus.in_valid = 1'b0;
      chk($sformatf("%s_busy_len%0d", tag, k), n, CW + 2);
    end else begin
      n = 1;
      while (bus.out_valid !== 1'b1 && n < 100) begin
        bus.in_valid = 1'b1;
        bus.pixel_in = JUNK;
        if (flip && n == CW + 4) bus.desc = ~bus.desc;
        step();
        n++;
      end
      bus.in_valid = 1'b0;
      chk($sformatf("%s_latency", tag), n, CW + 3 + N_IMG);
    end
  endtask

  task automatic check_frame_out(input string tag);
    for (int b = 0; b < N_IMG; b++) begin
      $display("%s beat %0d: valid=%0b color=%0d strength=%0d index=%0d", tag, b,
               bus.out_valid, bus.color_index, bus.strength_out, bus.image_out_index);
      chk($sformatf("%s_valid%0d", tag, b), 32'(bus.out_valid), 1);
      chk($sformatf("%s_color%0d", tag, b), 32'(bus.color_index), 32'(exp_col[b]));
      chk($sformatf("%s_strength%0d", tag, b), 32'(bus.strength_out), 32'(exp_str[b]));
      chk($sformatf("%s_index%0d", tag, b), 32'(bus.image_out_index), 32'(exp_idx[b]));
      step();
    end
    chk($sformatf("%s_valid_end", tag), 32'(bus.out_valid), 0);
    chk($sformatf("%s_busy_end", tag), 32'(bus.busy), 0);
    chk($sformatf("%s_hold", tag), 32'(bus.strength_out), 32'(exp_str[N_IMG-1]));
  endtask

  task automatic do_frame(input string tag, input logic d, input bit flip);
    bus.desc = d;
    for (int k = 0; k < N_IMG; k++)
      send_image(k, k == N_IMG - 1, flip, tag);
    check_frame_out(tag);
  endtask

  task automatic load_mixed();
    set_img(0, 2'd3, {8'd0, 8'd5, 8'd0}, {8'd0, 8'd5, 8'd0}, {8'd0, 8'd5, 8'd0}, {8'd0, 8'd5, 8'd0});
    set_img(1, 2'd0, {8'd0, 8'd0, 8'd25}, {8'd0, 8'd0, 8'd26}, {8'd1, 8'd2, 8'd24}, {8'd0, 8'd0, 8'd25});
    set_img(2, 2'd2, {8'd45, 8'd0, 8'd0}, {8'd45, 8'd0, 8'd0}, {8'd45, 8'd0, 8'd0}, {8'd46, 8'd0, 8'd0});
    set_img(3, 2'd1, {8'd15, 8'd0, 8'd0}, {8'd16, 8'd0, 8'd0}, {8'd14, 8'd0, 8'd0}, {8'd15, 8'd3, 8'd1});
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 0);
    chk({tag, "_color"}, 32'(bus.color_index), 0);
    chk({tag, "_strength"}, 32'(bus.strength_out), 0);
    chk({tag, "_index"}, 32'(bus.image_out_index), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset              = 1'b1;
    bus.in_valid       = 1'b0;
    bus.pixel_in       = '0;
    bus.image_in_index = '0;
    bus.desc           = 1'b0;
    step();
    step();
    check_reset_outputs("reset");
    reset = 1'b0;
    step();

    // Identical records: only the index decides the order.
    for (int k = 0; k < 4; k++)
      set_img(k, 2'd0, {8'd200, 8'd10, 8'd10}, {8'd200, 8'd10, 8'd10},
              {8'd200, 8'd10, 8'd10}, {8'd200, 8'd10, 8'd10});
    idx_tab[0] = 2'd3; idx_tab[1] = 2'd1; idx_tab[2] = 2'd0; idx_tab[3] = 2'd2;
    for (int b = 0; b < 4; b++) set_exp(b, 2'd0, 9'd400, 2'(b));
    do_frame("same", 1'b0, 1'b0);

    // (B,50,i0) (R,30,i1) (R,90,i2) (G,10,i3); desc flipped mid-sort must not matter.
    load_mixed();
    set_exp(0, 2'd0, 9'd90, 2'd2);
    set_exp(1, 2'd0, 9'd30, 2'd1);
    set_exp(2, 2'd1, 9'd10, 2'd3);
    set_exp(3, 2'd2, 9'd50, 2'd0);
    do_frame("mix_desc", 1'b1, 1'b1);

    set_exp(0, 2'd0, 9'd30, 2'd1);
    set_exp(1, 2'd0, 9'd90, 2'd2);
    do_frame("mix_asc", 1'b0, 1'b1);

    // Pixel R/G tie, count G/B tie, count R/G tie, duplicate indices.
    set_img(0, 2'd0, {8'd100, 8'd100, 8'd50}, {8'd100, 8'd100, 8'd50},
            {8'd100, 8'd100, 8'd50}, {8'd100, 8'd100, 8'd50});
    set_img(1, 2'd1, {8'd0, 8'd80, 8'd0}, {8'd0, 8'd80, 8'd0}, {8'd0, 8'd0, 8'd60}, {8'd0, 8'd0, 8'd60});
    set_img(2, 2'd1, {8'd10, 8'd20, 8'd30}, {8'd10, 8'd20, 8'd30},
            {8'd10, 8'd20, 8'd30}, {8'd10, 8'd20, 8'd30});
    set_img(3, 2'd0, {8'd50, 8'd0, 8'd0}, {8'd0, 8'd70, 8'd70}, {8'd30, 8'd0, 8'd0}, {8'd0, 8'd40, 8'd40});
    set_exp(0, 2'd0, 9'd80, 2'd0);
    set_exp(1, 2'd0, 9'd200, 2'd0);
    set_exp(2, 2'd1, 9'd160, 2'd1);
    set_exp(3, 2'd2, 9'd60, 2'd1);
    do_frame("ties", 1'b0, 1'b0);

    // Abort during the third image, then a clean frame must come out intact.
    load_mixed();
    bus.desc = 1'b1;
    send_image(0, 1'b0, 1'b0, "abort");
    send_image(1, 1'b0, 1'b0, "abort");
    send_pixel(pix_tab[2][0], idx_tab[2]);
    send_pixel(pix_tab[2][1], ~idx_tab[2]);
    reset = 1'b1;
    step();
    check_reset_outputs("midreset");
    reset = 1'b0;
    step();
    set_exp(0, 2'd0, 9'd90, 2'd2);
    set_exp(1, 2'd0, 9'd30, 2'd1);
    set_exp(2, 2'd1, 9'd10, 2'd3);
    set_exp(3, 2'd2, 9'd50, 2'd0);
    do_frame("fresh", 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
